ps2_arrow_router: RTL

PS2_ARROW_ROUTER -- requirements
Module: ps2_arrow_router

---
 rtl/ps2_arrow_router_pkg.sv | 51 +++++
 rtl/ps2_arrow_router_fifo.sv | 47 ++++
 rtl/ps2_arrow_router.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ps2_arrow_router_pkg.sv
// Shared scan-code constants, arrow encodings and prefix-state type for the
// PS/2 arrow router.
package ps2_arrow_router_pkg;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;

  localparam logic [7:0] SC_P1_UP    = 8'h1D;
  localparam logic [7:0] SC_P1_LEFT  = 8'h1C;
  localparam logic [7:0] SC_P1_DOWN  = 8'h1B;
  localparam logic [7:0] SC_P1_RIGHT = 8'h23;

  localparam logic [7:0] SC_P2_UP    = 8'h75;
  localparam logic [7:0] SC_P2_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P2_DOWN  = 8'h72;
  localparam logic [7:0] SC_P2_RIGHT = 8'h74;

  localparam logic [2:0] ARROW_NONE  = 3'b000;
  localparam logic [2:0] ARROW_UP    = 3'b001;
  localparam logic [2:0] ARROW_LEFT  = 3'b010;
  localparam logic [2:0] ARROW_DOWN  = 3'b011;
  localparam logic [2:0] ARROW_RIGHT = 3'b100;

  typedef enum logic [1:0] {
    PS_IDLE    = 2'd0,
    PS_EXT     = 2'd1,
    PS_BRK     = 2'd2,
    PS_EXT_BRK = 2'd3
  } prefix_state_e;

  function automatic logic [2:0] p1_decode(input logic [7:0] sc);
    case (sc)
      SC_P1_UP:    p1_decode = ARROW_UP;
      SC_P1_LEFT:  p1_decode = ARROW_LEFT;
      SC_P1_DOWN:  p1_decode = ARROW_DOWN;
      SC_P1_RIGHT: p1_decode = ARROW_RIGHT;
      default:     p1_decode = ARROW_NONE;
    endcase
  endfunction

  function automatic logic [2:0] p2_decode(input logic [7:0] sc);
    case (sc)
      SC_P2_UP:    p2_decode = ARROW_UP;
      SC_P2_LEFT:  p2_decode = ARROW_LEFT;
      SC_P2_DOWN:  p2_decode = ARROW_DOWN;
      SC_P2_RIGHT: p2_decode = ARROW_RIGHT;
      default:     p2_decode = ARROW_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_arrow_router_fifo.sv
// Small 3-bit event queue; a write into a full queue is taken only when a read
// frees a slot in the same cycle.
module arrow_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_en_i,
  input  logic [2:0] wr_data_i,
  input  logic       rd_en_i,
  output logic [2:0] rd_data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d  = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d  = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/ps2_arrow_router.sv
// Splits a PS/2 scan-code stream into two rate-limited arrow-event streams,
// one per player, with typematic-repeat suppression and overflow flags.
module ps2_arrow_router
  import ps2_arrow_router_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_out,
  output logic       player1_key_pressed,
  output logic [7:0] player1_arrow_input,
  output logic       player2_key_pressed,
  output logic [7:0] player2_arrow_input,
  output logic       player1_overflow,
  output logic       player2_overflow
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  prefix_state_e state_q, state_d;
  logic          is_make, is_break;
  logic [2:0]    code [2];

  assign code[0] = p1_decode(ps2_out);
  assign code[1] = p2_decode(ps2_out);

  always_comb begin
    state_d  = state_q;
    is_make  = 1'b0;
    is_break = 1'b0;
    if (ps2_key_pressed) begin
      case (state_q)
        PS_IDLE: begin
          if (ps2_out == SC_EXT)      state_d = PS_EXT;
          else if (ps2_out == SC_BRK) state_d = PS_BRK;
          else                        is_make = 1'b1;
        end
        PS_EXT: begin
          if (ps2_out == SC_BRK) state_d = PS_EXT_BRK;
          else begin
            is_make = 1'b1;
            state_d = PS_IDLE;
          end
        end
        default: begin
          is_break = 1'b1;
          state_d  = PS_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= PS_IDLE;
    else       state_q <= state_d;
  end

  for (genvar p = 0; p < 2; p++) begin : g_player
    logic [2:0]    held_q, held_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          pulse_q, ovf_q, ovf_d;
    logic [2:0]    arrow_q, arrow_d;
    logic          push, pop, full, empty;
    logic [2:0]    head;

    // A repeat of the held key is typematic and never reaches the queue.
    assign push = is_make && (code[p] != ARROW_NONE) && (code[p] != held_q);
    assign pop  = !empty && (gap_q == '0);

    always_comb begin
      held_d = held_q;
      if (push)
        held_d = code[p];
      else if (is_break && (code[p] != ARROW_NONE) && (code[p] == held_q))
        held_d = ARROW_NONE;
    end

    assign gap_d   = pop ? GW'(GAP_CYCLES - 1)
                   : (gap_q != '0) ? gap_q - GW'(1) : gap_q;
    assign arrow_d = pop ? head : arrow_q;
    assign ovf_d   = ovf_q | (push && full && !pop);

    arrow_event_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk_i    (clock),
      .rst_i    (reset),
      .wr_en_i  (push),
      .wr_data_i(code[p]),
      .rd_en_i  (pop),
      .rd_data_o(head),
      .full_o   (full),
      .empty_o  (empty)
    );

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        held_q  <= ARROW_NONE;
        gap_q   <= '0;
        pulse_q <= 1'b0;
        arrow_q <= ARROW_NONE;
        ovf_q   <= 1'b0;
      end else begin
        held_q  <= held_d;
        gap_q   <= gap_d;
        pulse_q <= pop;
        arrow_q <= arrow_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign player1_key_pressed = g_player[0].pulse_q;
  assign player1_arrow_input = {5'b0, g_player[0].arrow_q};
  assign player1_overflow    = g_player[0].ovf_q;
  assign player2_key_pressed = g_player[1].pulse_q;
  assign player2_arrow_input = {5'b0, g_player[1].arrow_q};
  assign player2_overflow    = g_player[1].ovf_q;

endmodule
